decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
// Registered, parametrised RV32/RV64 instruction decoder with valid/ready handshakes on both sides.
// Decodes each accepted instruction word into its fields, format, illegal flag and an XLEN-wide sign-extended immediate.
// Results are buffered in a DEPTH-entry FIFO between fetch and the PE execute stage, so fetch can run ahead.
// Replaces the flat combinational decoder; decodeComplete becomes a registered pulse.
// PARAMETERS
// XLEN       32  immediate/PC width (32 or 64)
// DEPTH      4   decoded-entry queue depth, power of two, >=2
// SUPPORT_M  0   1: funct7=0000001 on op 0x33 is legal (M extension)
// PORTS
// clk             in   1     clock, rising edge
// rst_n           in   1     asynchronous active-low reset
// flush           in   1     sync clear of queue (branch redirect)
// inValid         in   1     fetch presents instruction
// inReady         out  1     queue can accept (registered, = count<DEPTH)
// instruction     in   32    raw instruction word
// inPc            in   XLEN  PC of instruction
// outValid        out  1     head entry valid (= count!=0)
// outReady        in   1     execute consumes head
// op/funct3/funct7 out 7/3/7 head opcode and function fields
// rs1/rs2/rd      out  5     head register indices
// imm             out  XLEN  head immediate, sign-extended
// fmt             out  3     0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
// illegal         out  1     head is illegal instruction
// pcOut           out  XLEN  head PC
// decodeComplete  out  1     one-cycle pulse the cycle after any push
// count           out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
// - Reset (async, rst_n=0): rdPtr=wrPtr=count=0; outValid=0, inReady=1, decodeComplete=0; head fields/imm/pcOut/fmt/illegal=0.
// - Push when inValid&&inReady; pop when outValid&&outReady; both in one cycle allowed (count unchanged).
// - inReady depends only on registered count: no comb path from outReady; full queue refuses push even if popping.
// - Latency: push in cycle N with empty queue -> outValid=1 and fields valid in cycle N+1.
// - Head fields are read from the entry at rdPtr; stable while outValid&&!outReady.
// - Pointers wrap modulo DEPTH; count in 0..DEPTH.
// - Decoding (comb, before write): op=inst[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25] always.
// - fmt: 0x33->R; 0x13,0x03,0x67->I; 0x23->S; 0x63->B; 0x37,0x17->U; 0x6F->J.
// - imm: I={[31:20]}; S={[31:25],[11:7]}; B={[31],[7],[30:25],[11:8],0}; U={[31:12],12'b0}; J={[31],[19:12],[20],[30:21],0}; all sign-extended from bit 31 to XLEN; R: imm=0.
// - illegal=1, fmt=7, imm=0 if inst[1:0]!=2'b11, opcode not listed, or op=0x33 with funct7 not in {0000000,0100000,(0000001 if SUPPORT_M)}.
// - Illegal entries are still enqueued; execute raises the trap.
// - flush: next cycle count=0, pointers=0, outValid=0, inReady=1; flush wins over a same-cycle push (dropped, no decodeComplete) and pop.
// - decodeComplete registered: 1 in cycle N+1 iff push in N and no flush in N.
// - Reset mid-operation discards all entries immediately.
// TESTING
// 1 XOR 0x0021C0B3, outReady=1 -> next cycle outValid=1, op=0x33, fmt=0, rd=1, rs1=3, rs2=2, funct3=4, imm=0, decodeComplete pulse.
// 2 BEQ 0xFE000EE3 -> fmt=3, imm=0xFFFFFFFC (XLEN=32) / 0xFFFFFFFFFFFFFFFC (XLEN=64).
// 3 LUI 0x123450B7 -> fmt=4, rd=1, imm=0x12345000; JAL 0x0000006F -> fmt=5, imm=0.
// 4 DEPTH=4, outReady=0, 5 back-to-back pushes -> count=4, inReady=0 after 4th, 5th held; release outReady -> 4 entries out in order, then 5th.
// 5 0xFFFFFFFF and 0x02000033 (SUPPORT_M=0) -> illegal=1, fmt=7; same 0x02000033 with SUPPORT_M=1 -> legal R.
// 6 3 entries queued, flush with inValid=1 -> next cycle count=0, outValid=0, no decodeComplete; rst_n low mid-stream -> outputs zero immediately.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: registered RV32/RV64 instruction decoder feeding a DEPTH-entry FIFO.
// Each accepted instruction word is decoded combinationally (fields, format, illegal
// flag, sign-extended immediate) and written into the queue. The execute side reads
// the head entry through a valid/ready handshake, so fetch can run ahead.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous queue clear (branch redirect), beats push and pop
//   inValid/inReady fetch handshake; inReady derives only from the registered count
//   instruction     raw 32-bit instruction word
//   inPc            PC of the presented instruction
//   outValid/outReady execute handshake on the head entry
//   op, funct3, funct7, rs1, rs2, rd   head instruction fields
//   imm             head immediate, sign-extended to XLEN
//   fmt             0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   illegal         head is an illegal instruction
//   pcOut           head PC
//   decodeComplete  one-cycle pulse the cycle after an accepted push
//   count           queue occupancy, 0..DEPTH
module decode_queue #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 4,
    parameter bit          SUPPORT_M = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [31:0]             instruction,
    input  logic [XLEN-1:0]         inPc,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [6:0]              op,
    output logic [2:0]              funct3,
    output logic [6:0]              funct7,
    output logic [4:0]              rs1,
    output logic [4:0]              rs2,
    output logic [4:0]              rd,
    output logic [XLEN-1:0]         imm,
    output logic [2:0]              fmt,
    output logic                    illegal,
    output logic [XLEN-1:0]         pcOut,
    output logic                    decodeComplete,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic            funct7_ok;

    assign funct7_ok = (instruction[31:25] == 7'b0000000) ||
                       (instruction[31:25] == 7'b0100000) ||
                       (SUPPORT_M && (instruction[31:25] == 7'b0000001));

    always_comb begin
        dec_fmt   = FMT_ILL;
        dec_imm32 = '0;
        if (instruction[1:0] == 2'b11) begin
            case (instruction[6:0])
                7'h33: begin
                    if (funct7_ok) begin
                        dec_fmt = FMT_R;
                    end
                end
                7'h13, 7'h03, 7'h67: begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{instruction[31]}}, instruction[31:20]};
                end
                7'h23: begin
                    dec_fmt   = FMT_S;
                    dec_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                end
                7'h63: begin
                    dec_fmt   = FMT_B;
                    dec_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                                 instruction[30:25], instruction[11:8], 1'b0};
                end
                7'h37, 7'h17: begin
                    dec_fmt   = FMT_U;
                    dec_imm32 = {instruction[31:12], 12'b0};
                end
                7'h6F: begin
                    dec_fmt   = FMT_J;
                    dec_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                 instruction[20], instruction[30:21], 1'b0};
                end
                default: begin
                    dec_fmt   = FMT_ILL;
                    dec_imm32 = '0;
                end
            endcase
        end
    end

    // Bit 31 of the 32-bit immediate carries the sign out to XLEN.
    assign dec_imm = XLEN'($signed(dec_imm32));

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          dc_q;
    logic          push, pop;

    assign inReady  = (count_q < CW'(DEPTH));
    assign outValid = (count_q != '0);

    // Flush suppresses both sides so neither pointer moves in the redirect cycle.
    assign push = inValid && inReady && !flush;
    assign pop  = outValid && outReady && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dc_q     <= 1'b0;
        end else begin
            dc_q <= push;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry storage (contents only matter while counted as occupied)
    // ------------------------------------------------------------------
    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] imm_mem  [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [2:0]      fmt_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= instruction;
            imm_mem[wr_ptr_q]  <= dec_imm;
            pc_mem[wr_ptr_q]   <= inPc;
            fmt_mem[wr_ptr_q]  <= dec_fmt;
        end
    end

    // ------------------------------------------------------------------
    // Head outputs, forced to zero while empty so reset clears them at once
    // ------------------------------------------------------------------
    logic [31:0] head_inst;

    always_comb begin
        head_inst = '0;
        imm       = '0;
        pcOut     = '0;
        fmt       = '0;
        if (outValid) begin
            head_inst = inst_mem[rd_ptr_q];
            imm       = imm_mem[rd_ptr_q];
            pcOut     = pc_mem[rd_ptr_q];
            fmt       = fmt_mem[rd_ptr_q];
        end
    end

    assign op             = head_inst[6:0];
    assign rd             = head_inst[11:7];
    assign funct3         = head_inst[14:12];
    assign rs1            = head_inst[19:15];
    assign rs2            = head_inst[24:20];
    assign funct7         = head_inst[31:25];
    assign illegal        = outValid && (fmt == FMT_ILL);
    assign decodeComplete = dc_q;
    assign count          = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (RV32 without M, RV64 with M) driven by the
// same stimulus, compared each cycle against a queue-based reference model.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [63:0] drv_pc;
    logic        out_ready;

    always #5 clk = ~clk;

    // Instance a: XLEN=32, SUPPORT_M=0
    logic        a_inReady, a_outValid, a_illegal, a_dc;
    logic [6:0]  a_op, a_funct7;
    logic [2:0]  a_funct3, a_fmt;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [31:0] a_imm, a_pcOut;
    logic [2:0]  a_count;

    // Instance b: XLEN=64, SUPPORT_M=1
    logic        b_inReady, b_outValid, b_illegal, b_dc;
    logic [6:0]  b_op, b_funct7;
    logic [2:0]  b_funct3, b_fmt;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [63:0] b_imm, b_pcOut;
    logic [2:0]  b_count;

    decode_queue #(.XLEN(32), .DEPTH(4), .SUPPORT_M(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(in_valid), .inReady(a_inReady),
        .instruction(instr), .inPc(drv_pc[31:0]), .outValid(a_outValid), .outReady(out_ready),
        .op(a_op), .funct3(a_funct3), .funct7(a_funct7), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
        .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal), .pcOut(a_pcOut),
        .decodeComplete(a_dc), .count(a_count)
    );

    decode_queue #(.XLEN(64), .DEPTH(4), .SUPPORT_M(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(in_valid), .inReady(b_inReady),
        .instruction(instr), .inPc(drv_pc), .outValid(b_outValid), .outReady(out_ready),
        .op(b_op), .funct3(b_funct3), .funct7(b_funct7), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
        .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal), .pcOut(b_pcOut),
        .decodeComplete(b_dc), .count(b_count)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    localparam int QDEPTH = 4;
    ent_t q[$];
    bit   exp_dc = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decoding from the ISA rules using signed 64-bit arithmetic.
    task automatic model_decode(input logic [31:0] w, input bit m_ok,
                                output int fmt, output longint imm);
        longint s;
        bit     f7ok;
        s    = longint'($signed(w));
        f7ok = (w[31:25] == 7'h00) || (w[31:25] == 7'h20) || (m_ok && w[31:25] == 7'h01);
        fmt  = 7;
        imm  = 0;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h33: if (f7ok) fmt = 0;
                7'h13, 7'h03, 7'h67: begin
                    fmt = 1;
                    imm = s >>> 20;
                end
                7'h23: begin
                    fmt = 2;
                    imm = ((s >>> 25) <<< 5) | longint'(w[11:7]);
                end
                7'h63: begin
                    fmt = 3;
                    imm = ((s >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                          (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
                end
                7'h37, 7'h17: begin
                    fmt = 4;
                    imm = (s >>> 12) <<< 12;
                end
                7'h6F: begin
                    fmt = 5;
                    imm = ((s >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                          (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
                end
                default: fmt = 7;
            endcase
        end
    endtask

    task automatic check_state();
        int     fa, fb;
        longint ia, ib;
        bit     v;
        v = (q.size() != 0);
        check_eq("a_outValid", a_outValid, v);
        check_eq("b_outValid", b_outValid, v);
        check_eq("a_inReady", a_inReady, q.size() < QDEPTH);
        check_eq("b_inReady", b_inReady, q.size() < QDEPTH);
        check_eq("a_count", a_count, q.size());
        check_eq("b_count", b_count, q.size());
        check_eq("a_decodeComplete", a_dc, exp_dc);
        check_eq("b_decodeComplete", b_dc, exp_dc);
        if (v) begin
            model_decode(q[0].inst, 1'b0, fa, ia);
            model_decode(q[0].inst, 1'b1, fb, ib);
            check_eq("a_op", a_op, q[0].inst[6:0]);
            check_eq("a_rd", a_rd, q[0].inst[11:7]);
            check_eq("a_funct3", a_funct3, q[0].inst[14:12]);
            check_eq("a_rs1", a_rs1, q[0].inst[19:15]);
            check_eq("a_rs2", a_rs2, q[0].inst[24:20]);
            check_eq("a_funct7", a_funct7, q[0].inst[31:25]);
            check_eq("a_fmt", a_fmt, fa[2:0]);
            check_eq("a_illegal", a_illegal, fa == 7);
            check_eq("a_imm", a_imm, ia[31:0]);
            check_eq("a_pcOut", a_pcOut, q[0].pc[31:0]);
            check_eq("b_op", b_op, q[0].inst[6:0]);
            check_eq("b_rs2", b_rs2, q[0].inst[24:20]);
            check_eq("b_fmt", b_fmt, fb[2:0]);
            check_eq("b_illegal", b_illegal, fb == 7);
            check_eq("b_imm", b_imm, ib);
            check_eq("b_pcOut", b_pcOut, q[0].pc);
        end
    endtask

    // One cycle: check the current state at the negedge, then apply new inputs and
    // advance the model to what the next negedge should show.
    task automatic step(input bit iv, input logic [31:0] ins, input logic [63:0] pc,
                        input bit ordy, input bit fl);
        bit   push, pop;
        ent_t e;
        @(negedge clk);
        check_state();
        in_valid  = iv;
        instr     = ins;
        drv_pc    = pc;
        out_ready = ordy;
        flush     = fl;
        push   = iv && (q.size() < QDEPTH) && !fl;
        pop    = (q.size() != 0) && ordy && !fl;
        exp_dc = push;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e.inst = ins;
                e.pc   = pc;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 32'h0, 64'h0, ordy, 1'b0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          sel;
        w   = $urandom();
        sel = $urandom_range(0, 11);
        case (sel)
            0: begin
                w[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h23;
            5: w[6:0] = 7'h63;
            6: w[6:0] = 7'h37;
            7: w[6:0] = 7'h17;
            8: w[6:0] = 7'h6F;
            9: w[1:0] = 2'($urandom_range(0, 2));
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [63:0] p;
        p = {32'($urandom()), 32'($urandom())};
        p[1:0] = 2'b00;
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        drv_pc    = '0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_outValid", a_outValid, 1'b0);
        check_eq("rst_inReady", a_inReady, 1'b1);
        check_eq("rst_count", a_count, 3'd0);
        check_eq("rst_decodeComplete", a_dc, 1'b0);
        check_eq("rst_imm", b_imm, 64'h0);
        check_eq("rst_pcOut", b_pcOut, 64'h0);
        check_eq("rst_fmt", a_fmt, 3'd0);
        check_eq("rst_illegal", a_illegal, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // XOR
        step(1'b1, 32'h0021C0B3, 64'h1000, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("xor_outValid", a_outValid, 1'b1);
        check_eq("xor_op", a_op, 7'h33);
        check_eq("xor_fmt", a_fmt, 3'd0);
        check_eq("xor_rd", a_rd, 5'd1);
        check_eq("xor_rs1", a_rs1, 5'd3);
        check_eq("xor_rs2", a_rs2, 5'd2);
        check_eq("xor_funct3", a_funct3, 3'd4);
        check_eq("xor_imm", a_imm, 32'h0);
        check_eq("xor_dc", a_dc, 1'b1);

        // BEQ with negative offset
        step(1'b1, 32'hFE000EE3, 64'h1004, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("beq_fmt", a_fmt, 3'd3);
        check_eq("beq_imm32", a_imm, 32'hFFFFFFFC);
        check_eq("beq_imm64", b_imm, 64'hFFFFFFFFFFFFFFFC);

        // LUI, JAL
        step(1'b1, 32'h123450B7, 64'h1008, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("lui_fmt", a_fmt, 3'd4);
        check_eq("lui_rd", a_rd, 5'd1);
        check_eq("lui_imm", b_imm, 64'h12345000);
        step(1'b1, 32'h0000006F, 64'h100C, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("jal_fmt", a_fmt, 3'd5);
        check_eq("jal_imm", a_imm, 32'h0);

        // Illegal encodings and the M-extension funct7
        step(1'b1, 32'hFFFFFFFF, 64'h1010, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("ill_ffff_illegal", a_illegal, 1'b1);
        check_eq("ill_ffff_fmt", a_fmt, 3'd7);
        step(1'b1, 32'h02000033, 64'h1014, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("mul_noM_illegal", a_illegal, 1'b1);
        check_eq("mul_noM_fmt", a_fmt, 3'd7);
        check_eq("mul_M_illegal", b_illegal, 1'b0);
        check_eq("mul_M_fmt", b_fmt, 3'd0);
        idle(1'b1);

        // Fill to full with consumer stalled; fifth word held until space frees
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h00000013 | (32'(i + 1) << 20), 64'h2000 + 64'(i * 4), 1'b0, 1'b0);
        end
        step(1'b1, 32'h00500013, 64'h2010, 1'b0, 1'b0);
        check_eq("full_count", a_count, 3'd4);
        check_eq("full_inReady", a_inReady, 1'b0);
        step(1'b1, 32'h00500013, 64'h2010, 1'b0, 1'b0);
        step(1'b1, 32'h00500013, 64'h2010, 1'b1, 1'b0);
        check_eq("full_pop_noPush", a_inReady, 1'b0);
        step(1'b1, 32'h00500013, 64'h2010, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Flush with a simultaneous push
        for (int i = 0; i < 3; i++) step(1'b1, rand_inst(), rand_pc(), 1'b0, 1'b0);
        step(1'b1, rand_inst(), rand_pc(), 1'b1, 1'b1);
        idle(1'b0);
        check_eq("flush_count", a_count, 3'd0);
        check_eq("flush_outValid", a_outValid, 1'b0);
        check_eq("flush_dc", a_dc, 1'b0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, rand_inst(), rand_pc(), 1'b0, 1'b0);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_outValid", a_outValid, 1'b0);
        check_eq("arst_count", b_count, 3'd0);
        check_eq("arst_inReady", a_inReady, 1'b1);
        check_eq("arst_imm", b_imm, 64'h0);
        check_eq("arst_pcOut", a_pcOut, 32'h0);
        check_eq("arst_op", a_op, 7'h0);
        q.delete();
        exp_dc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), rand_pc(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
